// File: rtl/dmem_mmio.sv
// ---------------------------------------------------------------------------
// dmem_mmio
//
// Data-side responder for the single-cycle CPU load/store port. It holds a
// word-addressed data RAM plus a small memory-mapped I/O block: an LED
// register, a two-flop synchronised switch input and, optionally, a compare
// timer that raises an interrupt flag.
//
// Loads are answered combinationally in the same cycle. Stores commit on the
// rising clock edge.
//
// Parameters:
//   DEPTH_LOG2 - log2 of RAM depth in 32-bit words (default 7 = 128 words)
//   MMIO_HI    - value of addr[31:16] that selects the MMIO region
//
// Ports:
//   clk   in   1   clock, all state updates on the rising edge
//   rst   in   1   asynchronous, active-low reset
//   addr  in  32   byte address from the CPU ALU
//   wdata in  32   store data
//   we    in   1   memory write strobe
//   rdata out 32   load data, combinational from addr and current state
//   sw    in  16   asynchronous switch inputs
//   led   out 16   LED register
//   irq   out  1   timer interrupt (the FLAG bit)
//
// MMIO offsets (addr[15:0]):
//   0x00 LED (rw)   0x04 SW (ro)   0x08 CNT (ro)   0x0C CMP (rw)
//   0x10 CTRL: bit0 EN, bit1 RELOAD, bit2 FLAG (write 1 to clear)
//
// Build option:
//   DMEM_MMIO_TIMER_EN - when defined, the CNT/CMP/CTRL timer and irq are
//   built. When it is undefined, the timer offsets read 0, writes to them are
//   ignored, and irq is tied to 0.
// ---------------------------------------------------------------------------
module dmem_mmio #(
  parameter int          DEPTH_LOG2 = 7,
  parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [15:0] OFF_LED  = 16'h0000;
  localparam logic [15:0] OFF_SW   = 16'h0004;
  localparam logic [15:0] OFF_CNT  = 16'h0008;
  localparam logic [15:0] OFF_CMP  = 16'h000C;
  localparam logic [15:0] OFF_CTRL = 16'h0010;

  logic [31:0]           mem [DEPTH];
  logic                  is_mmio;
  logic [15:0]           offset;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_we;
  logic                  mmio_we;
  logic [15:0]           sw_meta;
  logic [15:0]           sw_sync;

  assign is_mmio = (addr[31:16] == MMIO_HI);
  assign offset  = addr[15:0];
  // Upper address bits and the byte offset are ignored, so the RAM aliases.
  assign ram_idx = addr[DEPTH_LOG2+1:2];
  // Gating with rst drops a RAM store that coincides with reset, matching
  // the MMIO registers, which are held in reset at that edge.
  assign ram_we  = we & ~is_mmio & rst;
  assign mmio_we = we & is_mmio;

  // RAM has no reset, so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= wdata;
    end
  end

  // Switch synchroniser. SW reads 0 until two edges after a change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= 16'h0000;
      sw_sync <= 16'h0000;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= 16'h0000;
    end else if (mmio_we && offset == OFF_LED) begin
      led <= wdata[15:0];
    end
  end

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        en;
  logic        reload;
  logic        flag;
  logic        wr_cmp;
  logic        wr_ctrl;
  logic        match;

  assign wr_cmp  = mmio_we && offset == OFF_CMP;
  assign wr_ctrl = mmio_we && offset == OFF_CTRL;
  // The comparison uses the CMP value already registered, so a new CMP
  // takes part in matching only from the following cycle.
  assign match   = en && (cnt == cmp);

  // A CMP write clears CNT and overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 32'h0000_0000;
      cmp <= 32'hFFFF_FFFF;
    end else if (wr_cmp) begin
      cmp <= wdata;
      cnt <= 32'h0000_0000;
    end else if (en) begin
      cnt <= (match && reload) ? 32'h0000_0000 : cnt + 32'd1;
    end
  end

  // If a match and a W1C land in the same cycle, the match wins and
  // FLAG stays set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en     <= 1'b0;
      reload <= 1'b0;
      flag   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= wdata[0];
        reload <= wdata[1];
      end
      if (match) begin
        flag <= 1'b1;
      end else if (wr_ctrl && wdata[2]) begin
        flag <= 1'b0;
      end
    end
  end

  assign irq = flag;
`else
  assign irq = 1'b0;
`endif

  // Zero-latency load mux. Unmapped MMIO offsets read 0.
  always_comb begin
    rdata = 32'h0000_0000;
    if (is_mmio) begin
      case (offset)
        OFF_LED:  rdata = {16'h0000, led};
        OFF_SW:   rdata = {16'h0000, sw_sync};
`ifdef DMEM_MMIO_TIMER_EN
        OFF_CNT:  rdata = cnt;
        OFF_CMP:  rdata = cmp;
        OFF_CTRL: rdata = {29'h0, flag, reload, en};
`endif
        default:  rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = mem[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// ---------------------------------------------------------------------------
// tb_dmem_mmio
//
// Directed self-checking bench for dmem_mmio. It exercises RAM store/load and
// aliasing, LED and switch MMIO, unmapped offsets, asynchronous reset and the
// compare timer (or its absence when DMEM_MMIO_TIMER_EN is undefined).
// ---------------------------------------------------------------------------
module tb_dmem_mmio;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic        irq;

  int total_count;
  int bad_count;

  localparam logic [31:0] A_LED  = 32'hFFFF_0000;
  localparam logic [31:0] A_SW   = 32'hFFFF_0004;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0010;

  dmem_mmio dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .sw    (sw),
    .led   (led),
    .irq   (irq)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_count++;
    if (got !== exp) begin
      bad_count++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a store on the falling edge, let it commit on the next rising
  // edge, then drop we 1 ns later.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
  endtask

  // Combinational load: drive the address, settle, then compare.
  task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] exp);
    we   = 1'b0;
    addr = a;
    #1;
    checkOutput(tag, rdata, exp);
  endtask

  // Advance one rising edge and sample 1 ns after it.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int irq_high;
    total_count = 0;
    bad_count   = 0;
    rst   = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    we    = 1'b0;
    sw    = 16'h0000;
    irq_high = 0;

    // Outputs while reset is held.
    #12;
    checkOutput("reset_led", {16'h0, led}, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    readCheck("reset_sw", A_SW, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // RAM store/load and aliasing.
    applyStimulus(32'h0000_0010, 32'hDEAD_BEEF);
    readCheck("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    readCheck("ram_alias_lo", 32'h0000_0210, 32'hDEAD_BEEF);
    readCheck("ram_alias_hi", 32'h0001_0013, 32'hDEAD_BEEF);
    applyStimulus(32'h0000_0014, 32'h1234_5678);
    readCheck("ram_rd2", 32'h0000_0014, 32'h1234_5678);
    readCheck("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

    // LED register.
    applyStimulus(A_LED, 32'hFFFF_1234);
    checkOutput("led_pin", {16'h0, led}, 32'h0000_1234);
    readCheck("led_rd", A_LED, 32'h0000_1234);

    // Switch synchroniser latency.
    sw = 16'hA5A5;
    readCheck("sw_edge0", A_SW, 32'h0);
    stepEdge();
    readCheck("sw_edge1", A_SW, 32'h0);
    stepEdge();
    readCheck("sw_edge2", A_SW, 32'h0000_A5A5);

    // Writes to read-only and unmapped offsets are ignored.
    applyStimulus(A_SW, 32'h0000_1111);
    readCheck("sw_ro", A_SW, 32'h0000_A5A5);
    applyStimulus(32'hFFFF_0020, 32'hCAFE_F00D);
    readCheck("unmapped", 32'hFFFF_0020, 32'h0);
    readCheck("led_after", A_LED, 32'h0000_1234);

`ifdef DMEM_MMIO_TIMER_EN
    // Reload mode with CMP=3: expect CNT = 0,1,2,3,0,1.
    applyStimulus(A_CMP, 32'd3);
    readCheck("cmp_rd", A_CMP, 32'd3);
    applyStimulus(A_CTRL, 32'h3);
    readCheck("cnt_0", A_CNT, 32'd0);
    stepEdge(); readCheck("cnt_1", A_CNT, 32'd1);
    stepEdge(); readCheck("cnt_2", A_CNT, 32'd2);
    stepEdge(); readCheck("cnt_3", A_CNT, 32'd3);
    checkOutput("irq_before", {31'h0, irq}, 32'h0);
    stepEdge(); readCheck("cnt_wrap0", A_CNT, 32'd0);
    checkOutput("irq_after", {31'h0, irq}, 32'h1);
    stepEdge(); readCheck("cnt_wrap1", A_CNT, 32'd1);
    // W1C at CNT=1 (no match): flag clears and EN/RELOAD stay set.
    applyStimulus(A_CTRL, 32'h7);
    checkOutput("irq_w1c", {31'h0, irq}, 32'h0);
    readCheck("ctrl_w1c", A_CTRL, 32'h3);
    readCheck("cnt_w1c", A_CNT, 32'd2);

    // Collision test: the match sets FLAG while W1C clears it in the same cycle.
    applyStimulus(A_CTRL, 32'h0);
    applyStimulus(A_CMP, 32'd5);
    applyStimulus(A_CTRL, 32'h1);
    readCheck("cnt_start", A_CNT, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    readCheck("cnt_5", A_CNT, 32'd5);
    checkOutput("irq_pre5", {31'h0, irq}, 32'h0);
    applyStimulus(A_CTRL, 32'h5);
    checkOutput("irq_setwins", {31'h0, irq}, 32'h1);
    readCheck("cnt_6", A_CNT, 32'd6);
    readCheck("ctrl_setwins", A_CTRL, 32'h5);
    applyStimulus(A_CTRL, 32'h5);
    checkOutput("irq_clr", {31'h0, irq}, 32'h0);
    readCheck("cnt_7", A_CNT, 32'd7);

    // Prepare for the reset test: LED 0x00FF and CNT at 0x20.
    applyStimulus(A_LED, 32'h0000_00FF);
    applyStimulus(A_CMP, 32'd100);
    repeat (32) @(posedge clk);
    #1;
    readCheck("cnt_20", A_CNT, 32'h20);
`else
    // Timer not built: its registers read 0 and irq stays low.
    applyStimulus(A_CTRL, 32'h7);
    applyStimulus(A_CMP, 32'd5);
    readCheck("notmr_cnt", A_CNT, 32'h0);
    readCheck("notmr_cmp", A_CMP, 32'h0);
    readCheck("notmr_ctrl", A_CTRL, 32'h0);
    for (int i = 0; i < 100; i++) begin
      stepEdge();
      if (irq !== 1'b0) irq_high++;
    end
    checkOutput("notmr_irq_cycles", irq_high, 0);
    applyStimulus(A_LED, 32'h0000_00FF);
`endif

    // Assert async reset between edges.
    checkOutput("led_ff", {16'h0, led}, 32'h0000_00FF);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_led", {16'h0, led}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    readCheck("rst_sw", A_SW, 32'h0);
`ifdef DMEM_MMIO_TIMER_EN
    readCheck("rst_cnt", A_CNT, 32'h0);
    readCheck("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    readCheck("rst_ctrl", A_CTRL, 32'h0);
`endif
    // A store issued during reset must be lost.
    @(negedge clk);
    addr  = 32'h0000_0010;
    wdata = 32'h0BAD_0BAD;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    readCheck("ram_after_rst", 32'h0000_0010, 32'hDEAD_BEEF);
    readCheck("ram2_after_rst", 32'h0000_0014, 32'h1234_5678);
    checkOutput("led_after_rst", {16'h0, led}, 32'h0);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side responder for the single-cycle CPU's load/store port: word-addressed data RAM plus a small memory-mapped I/O block (LED register, synchronized switch input, compare timer with interrupt flag).
- Consumes the core's ALU address, store data and memory-write strobe; returns load data in the same cycle.
- Sits beside the core at SoC top level, in place of a bare RAM.

Parameters:
- DEPTH_LOG2, 7, log2 of RAM depth in 32-bit words (128 words default).
- MMIO_HI, 16'hFFFF, value of addr[31:16] that selects the MMIO region.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from the CPU ALU output.
- wdata  input  32  store data.
- we  input  1  memory write strobe.
- rdata  output  32  load data, combinational from addr and current state.
- sw  input  16  asynchronous switch inputs.
- led  output  16  LED register.
- irq  output  1  timer interrupt, equal to the FLAG bit.

Behaviour:
- Decode: MMIO when addr[31:16]==MMIO_HI, otherwise RAM.
- RAM index is addr[DEPTH_LOG2+1:2]. Upper bits are ignored (aliasing) and addr[1:0] is ignored. Word access only.
- Read path: rdata is purely combinational (zero latency), as the single-cycle core requires.
- Write path: when we=1, the write commits at the clock edge. A read of the same address in the next cycle returns the new data.
- RAM contents are not reset (X until written).
- MMIO map, offset addr[15:0]:
  - 0x00 LED: read/write, low 16 bits, upper bits read 0.
  - 0x04 SW: read-only; the 2-flop synchronized sw value, zero-extended.
  - 0x08 CNT: read-only 32-bit counter.
  - 0x0C CMP: read/write 32-bit. A write also clears CNT to 0 at the same edge.
  - 0x10 CTRL: bit0 EN, bit1 RELOAD, bit2 FLAG.
    - Writing 1 to bit2 clears FLAG (W1C); writing 0 leaves it.
    - Bits 0 and 1 are written directly.
    - Other bits read 0.
  - Any other MMIO offset reads 0; writes to it are ignored. Writes to SW and CNT are ignored.
- Timer, per cycle when EN=1 (priority order):
  - If CNT==CMP: set FLAG; next CNT = 0 if RELOAD=1, else CNT+1.
  - Otherwise CNT+1.
  - CNT wraps modulo 2^32.
  - EN=0 holds CNT.
- Simultaneous events:
  - Timer match and W1C of FLAG in the same cycle: FLAG ends at 1 (set wins).
  - CMP write and timer increment in the same cycle: CNT ends at 0 (write wins).
  - CMP write takes effect for comparison from the next cycle.
- Reset (async assert, sync release):
  - LED, CNT, EN, RELOAD and FLAG go to 0; CMP goes to 32'hFFFF_FFFF; synchronizer flops go to 0.
  - Hence led=0, irq=0, SW reads 0 until two edges after release.
  - Reset asserted mid-count aborts counting immediately.
  - A write coincident with reset is lost.
- irq is registered (FLAG); it asserts one cycle after the matching edge is sampled, i.e. visible after the edge where CNT==CMP was true.

Optional Feature:
- Macro DMEM_MMIO_TIMER_EN.
- Defined: CNT/CMP/CTRL and irq behave as above.
- Undefined:
  - No timer flops are synthesized.
  - Offsets 0x08, 0x0C and 0x10 read 0 and writes are ignored.
  - irq is tied to 0.
  - LED, SW and RAM are unchanged.

Test Plan:
- RAM write/read: we=1, addr=0x0000_0010, wdata=0xDEADBEEF; next cycle addr=0x10, we=0 -> rdata=0xDEADBEEF. With DEPTH_LOG2=7, addr=0x0000_0210 also returns 0xDEADBEEF (alias).
- LED/SW:
  - Write 0xFFFF_1234 to 0xFFFF0000 -> led=0x1234; reading it returns 0x0000_1234.
  - sw=0xA5A5 held -> reading 0xFFFF0004 returns 0x0000A5A5 from the 2nd edge after the change, 0 before.
- Timer reload: write CMP=3 at 0xFFFF000C, then CTRL=0x3.
  - CNT sequence observed is 0,1,2,3,0,1,...
  - irq rises after the first CNT==3 edge.
  - Writing CTRL=0x7 clears irq while EN and RELOAD remain set.
- Set-wins collision: with EN=1, RELOAD=0, CMP=5, issue the W1C write to CTRL in the cycle where CNT==5 -> FLAG/irq=1 afterwards, and CNT continues to 6.
- Async reset mid-count: assert rst=0 between edges while CNT=0x20 and led=0x00FF.
  - Immediately led=0, irq=0, CNT=0, CMP=0xFFFFFFFF.
  - After release, a RAM word written before reset still reads its value.
- Compile with DMEM_MMIO_TIMER_EN undefined: write 0x7 to CTRL and 5 to CMP -> reads of 0x08, 0x0C and 0x10 return 0, and irq stays 0 for 100 cycles.
